// File: rtl/adex_tdm_scheduler.sv
// Time-multiplexes one AdEx update engine across N_NEURONS virtual neurons.
// Per-neuron state lives here; each tick sweeps every neuron through the engine once.
module adex_tdm_scheduler #(
  parameter int unsigned N_NEURONS = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned NB        = 24,
  parameter logic signed [NB-1:0] EL     = 24'shFEDED3,
  parameter logic signed [NB-1:0] W_INIT = 24'sh0025AE,
  parameter logic signed [NB-1:0] E_INIT = 24'sh00002B
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  output logic [IDX_W-1:0]     cur_addr,
  input  logic signed [NB-1:0] cur_data,
  output logic                 dp_valid,
  input  logic                 dp_ready,
  output logic signed [NB-1:0] dp_V,
  output logic signed [NB-1:0] dp_W,
  output logic signed [NB-1:0] dp_VP,
  output logic signed [NB-1:0] dp_e,
  output logic signed [NB-1:0] dp_I,
  input  logic                 dp_res_valid,
  input  logic signed [NB-1:0] dp_V_n,
  input  logic signed [NB-1:0] dp_W_n,
  input  logic signed [NB-1:0] dp_VP_n,
  input  logic signed [NB-1:0] dp_e_n,
  input  logic                 dp_spike,
  output logic                 busy,
  output logic                 done,
  output logic                 spike_valid,
  output logic [IDX_W-1:0]     spike_id,
  output logic                 overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  if (IDX_W != $clog2(N_NEURONS)) begin : g_bad_idx_w
    $error("IDX_W must equal clog2(N_NEURONS)");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic signed [NB-1:0]  v_mem  [N_NEURONS];
  logic signed [NB-1:0]  w_mem  [N_NEURONS];
  logic signed [NB-1:0]  vp_mem [N_NEURONS];
  logic signed [NB-1:0]  e_mem  [N_NEURONS];

  // Operands are read straight from the arrays; idx is frozen while stalled in ISSUE.
  assign cur_addr = idx;
  assign dp_V     = v_mem[idx];
  assign dp_W     = w_mem[idx];
  assign dp_VP    = vp_mem[idx];
  assign dp_e     = e_mem[idx];
  assign dp_I     = cur_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      dp_valid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      spike_valid <= 1'b0;
      spike_id    <= '0;
      overrun     <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i]  <= EL;
        vp_mem[i] <= EL;
        w_mem[i]  <= W_INIT;
        e_mem[i]  <= E_INIT;
      end
    end else begin
      done        <= 1'b0;
      spike_valid <= 1'b0;
      if (tick && (state != S_IDLE)) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (tick) begin
            idx      <= '0;
            state    <= S_ISSUE;
            dp_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (dp_ready) begin
            state    <= S_WAIT;
            dp_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          // Write back the single in-flight neuron, then advance or finish the sweep.
          if (dp_res_valid) begin
            v_mem[idx]  <= dp_V_n;
            w_mem[idx]  <= dp_W_n;
            vp_mem[idx] <= dp_VP_n;
            e_mem[idx]  <= dp_e_n;
            if (dp_spike) begin
              spike_valid <= 1'b1;
              spike_id    <= idx;
            end
            if (idx == LAST_IDX) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              state    <= S_ISSUE;
              dp_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          dp_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adex_tdm_scheduler.sv
// Directed bench for adex_tdm_scheduler with N_NEURONS=4; a cycle-stepped
// datapath model in the stimulus returns V+1, W-1, VP+2, e^1 per neuron.
module tb_adex_tdm_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned NB = 24;
  localparam logic signed [NB-1:0] EL = 24'shFEDED3;
  localparam logic signed [NB-1:0] WI = 24'sh0025AE;
  localparam logic signed [NB-1:0] EI = 24'sh00002B;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tick = 1'b0;
  logic [IW-1:0]        cur_addr;
  logic signed [NB-1:0] cur_data = '0;
  logic                 dp_valid;
  logic                 dp_ready = 1'b0;
  logic signed [NB-1:0] dp_V, dp_W, dp_VP, dp_e, dp_I;
  logic                 dp_res_valid = 1'b0;
  logic signed [NB-1:0] dp_V_n = '0, dp_W_n = '0, dp_VP_n = '0, dp_e_n = '0;
  logic                 dp_spike = 1'b0;
  logic                 busy, done, spike_valid, overrun;
  logic [IW-1:0]        spike_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int spikes = 0;
  int lat;
  logic signed [NB-1:0] ev [N];
  logic signed [NB-1:0] ew [N];
  logic signed [NB-1:0] evp[N];
  logic signed [NB-1:0] ee [N];

  adex_tdm_scheduler #(
    .N_NEURONS(N), .IDX_W(IW), .NB(NB), .EL(EL), .W_INIT(WI), .E_INIT(EI)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .cur_addr(cur_addr), .cur_data(cur_data),
    .dp_valid(dp_valid), .dp_ready(dp_ready),
    .dp_V(dp_V), .dp_W(dp_W), .dp_VP(dp_VP), .dp_e(dp_e), .dp_I(dp_I),
    .dp_res_valid(dp_res_valid),
    .dp_V_n(dp_V_n), .dp_W_n(dp_W_n), .dp_VP_n(dp_VP_n), .dp_e_n(dp_e_n),
    .dp_spike(dp_spike),
    .busy(busy), .done(done),
    .spike_valid(spike_valid), .spike_id(spike_id),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      ev[i] = EL; evp[i] = EL; ew[i] = WI; ee[i] = EI;
    end
  endtask

  task automatic check_issue(input int k);
    chk("issue_valid", 32'(dp_valid), 32'd1);
    chk("issue_busy",  32'(busy),     32'd1);
    chk("issue_addr",  32'(cur_addr), 32'(k));
    chk("issue_V",     32'(dp_V),     32'(ev[k]));
    chk("issue_W",     32'(dp_W),     32'(ew[k]));
    chk("issue_VP",    32'(dp_VP),    32'(evp[k]));
    chk("issue_e",     32'(dp_e),     32'(ee[k]));
    chk("issue_I",     32'(dp_I),     32'(cur_data));
  endtask

  // Serve one neuron: optional ready stall, handshake, one-cycle result.
  task automatic serve(input int k, input int stall, input logic spike, input logic tick_mid);
    cur_data = NB'(k * 16 + 5);
    check_issue(k);
    for (int s = 0; s < stall; s++) begin
      dp_ready = 1'b0;
      dp_res_valid = 1'b1;          // stray result outside WAIT must be ignored
      dp_spike = 1'b1;
      dp_V_n = 24'sh7A7A7A;
      step();
      dp_res_valid = 1'b0;
      dp_spike = 1'b0;
      chk("stall_valid", 32'(dp_valid), 32'd1);
      chk("stall_addr",  32'(cur_addr), 32'(k));
      chk("stall_V",     32'(dp_V),     32'(ev[k]));
      chk("stall_spk",   32'(spike_valid), 32'd0);
    end
    dp_ready = 1'b1;
    tick = tick_mid;
    step();
    dp_ready = 1'b0;
    tick = 1'b0;
    chk("wait_valid", 32'(dp_valid), 32'd0);
    chk("wait_done",  32'(done),     32'd0);
    dp_res_valid = 1'b1;
    dp_V_n  = ev[k] + 24'sd1;
    dp_W_n  = ew[k] - 24'sd1;
    dp_VP_n = evp[k] + 24'sd2;
    dp_e_n  = ee[k] ^ 24'sh000001;
    dp_spike = spike;
    step();
    dp_res_valid = 1'b0;
    dp_spike = 1'b0;
    ev[k] = ev[k] + 24'sd1;
    ew[k] = ew[k] - 24'sd1;
    evp[k] = evp[k] + 24'sd2;
    ee[k] = ee[k] ^ 24'sh000001;
    chk("spike_valid", 32'(spike_valid), 32'(spike));
    if (spike_valid) spikes++;
    if (spike) chk("spike_id", 32'(spike_id), 32'(k));
  endtask

  task automatic sweep(input logic [N-1:0] mask, input int stall_k, input int stall_n,
                       input int tick_mid_k, input logic tick_done, output int latency);
    tick = 1'b1;
    step();
    tick = 1'b0;
    cyc = 0;
    for (int k = 0; k < N; k++)
      serve(k, (k == stall_k) ? stall_n : 0, mask[k], k == tick_mid_k);
    latency = cyc + 1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy",  32'(busy), 32'd1);
    tick = tick_done;
    step();
    tick = 1'b0;
    chk("post_done",  32'(done),     32'd0);
    chk("post_busy",  32'(busy),     32'd0);
    chk("post_valid", 32'(dp_valid), 32'd0);
    if (tick_done) begin
      step();
      chk("no_restart_busy",  32'(busy),     32'd0);
      chk("no_restart_valid", 32'(dp_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("idle_busy",    32'(busy),        32'd0);
    chk("idle_valid",   32'(dp_valid),    32'd0);
    chk("idle_done",    32'(done),        32'd0);
    chk("idle_overrun", 32'(overrun),     32'd0);
    chk("idle_spike",   32'(spike_valid), 32'd0);
    chk("idle_spk_id",  32'(spike_id),    32'd0);
    reset_model();

    // Zero-wait sweeps: reset operands first, then EL+1 on the second pass.
    sweep('0, -1, 0, -1, 1'b0, lat);
    chk("lat_zero_wait", 32'(lat), 32'd9);
    sweep('0, -1, 0, -1, 1'b0, lat);
    chk("lat_second", 32'(lat), 32'd9);

    sweep('0, 2, 5, -1, 1'b0, lat);
    chk("lat_backpressure", 32'(lat), 32'd14);

    spikes = 0;
    sweep(4'b1010, -1, 0, -1, 1'b0, lat);
    chk("spike_count", 32'(spikes), 32'd2);
    chk("overrun_clear", 32'(overrun), 32'd0);

    sweep('0, -1, 0, 1, 1'b1, lat);
    chk("lat_overrun", 32'(lat), 32'd9);
    chk("overrun_set", 32'(overrun), 32'd1);
    sweep('0, -1, 0, -1, 1'b0, lat);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while neuron 2 is in WAIT, then a late result that must be dropped.
    tick = 1'b1;
    step();
    tick = 1'b0;
    serve(0, 0, 1'b0, 1'b0);
    serve(1, 0, 1'b0, 1'b0);
    cur_data = NB'(37);
    check_issue(2);
    dp_ready = 1'b1;
    step();
    dp_ready = 1'b0;
    chk("mid_wait_valid", 32'(dp_valid), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    dp_res_valid = 1'b1;
    dp_spike = 1'b1;
    dp_V_n = 24'sh123456;
    step();
    dp_res_valid = 1'b0;
    dp_spike = 1'b0;
    chk("mid_rst_busy",    32'(busy),        32'd0);
    chk("mid_rst_valid",   32'(dp_valid),    32'd0);
    chk("mid_rst_spike",   32'(spike_valid), 32'd0);
    chk("mid_rst_overrun", 32'(overrun),     32'd0);
    step();
    chk("mid_rst_spike2",  32'(spike_valid), 32'd0);
    reset_model();
    sweep('0, -1, 0, -1, 1'b0, lat);
    chk("lat_after_rst", 32'(lat), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adex_tdm_scheduler.md
Name: adex_tdm_scheduler

Overview:
- Time-multiplexes one shared AdEx update datapath across N_NEURONS virtual neurons.
- Holds per-neuron state (V, W, VP, e) in internal register arrays.
- On each timestep tick, issues every neuron in index order to the datapath over a valid/ready handshake, writes back the returned state, and emits spike events tagged with the neuron index.
- Sits between the network timestep controller / input-current memory and a single AdEx update engine.

Parameters:
- N_NEURONS, 16, number of virtual neurons (≥2).
- IDX_W, 4, neuron index width; must equal clog2(N_NEURONS).
- NB, 24, state word width (signed, 4.20 fixed point).
- EL, 24'shFEDED3, reset value of V and VP.
- W_INIT, 24'sh0025AE, reset value of W.
- E_INIT, 24'sh00002B, reset value of e.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  start-of-timestep pulse.
- cur_addr  out  IDX_W  index of the current-memory word being read; equals idx.
- cur_data  in  NB  signed input current for cur_addr; combinational read, same cycle.
- dp_valid  out  1  operand valid to datapath.
- dp_ready  in  1  datapath accepts operands.
- dp_V, dp_W, dp_VP, dp_e, dp_I  out  NB each  operands for neuron idx.
- dp_res_valid  in  1  result valid from datapath.
- dp_V_n, dp_W_n, dp_VP_n, dp_e_n  in  NB each  updated state.
- dp_spike  in  1  datapath spike flag, qualified by dp_res_valid.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at the end of the timestep.
- spike_valid  out  1  one-cycle spike event.
- spike_id  out  IDX_W  index of the spiking neuron.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (synchronous):
  - Every neuron: V=EL, VP=EL, W=W_INIT, e=E_INIT.
  - idx=0, FSM=IDLE.
  - dp_valid, done, spike_valid, overrun, busy = 0; spike_id = 0.
  - Reset mid-timestep aborts the sweep at that edge. An in-flight result is discarded; any dp_res_valid after reset is ignored.
- FSM states and transitions:
  - IDLE: tick=1 → idx=0, go to ISSUE.
  - ISSUE:
    - dp_valid=1. dp_V/W/VP/e = state[idx]; dp_I = cur_data.
    - Operands are combinational from the arrays and stay stable while dp_valid && !dp_ready.
    - Handshake (dp_valid && dp_ready) → WAIT.
  - WAIT:
    - dp_valid=0. Hold until dp_res_valid.
    - On dp_res_valid: write dp_*_n into state[idx].
    - If dp_spike: on the next cycle spike_valid=1 and spike_id=idx (registered).
    - Then, if idx==N_NEURONS-1 → DONE; else idx+1 → ISSUE.
  - DONE: done=1 for exactly this cycle → IDLE.
- Handshake rules:
  - Exactly one neuron is in flight at a time.
  - dp_res_valid is ignored outside WAIT.
  - dp_spike is ignored unless dp_res_valid is high in WAIT.
- Latency:
  - Each neuron takes at least 2 cycles (ISSUE with dp_ready=1, then WAIT with dp_res_valid=1).
  - Tick sampled at cycle T: first ISSUE at T+1; done asserted at T+2N+1 for a zero-wait datapath.
  - spike_valid for neuron k appears the cycle after its WAIT-capture cycle.
- Tick outside IDLE (including the DONE cycle): ignored and overrun set to 1. Only rst clears overrun.
- No arithmetic on state: the block stores and forwards full NB-bit words unmodified. idx does not wrap; the sweep terminates at N_NEURONS-1.
- State arrays are written only by WAIT capture and by reset; no other write path.

Test Plan:
- Reset/idle (N=4): rst 1 cycle then no tick for 10 cycles → busy=0, dp_valid=0, done=0, overrun=0. First issued operands are V=VP=24'shFEDED3, W=24'sh0025AE, e=24'sh00002B.
- Zero-wait sweep: datapath model with dp_ready=1 that returns V_n=V+1 the cycle after the handshake; tick at T → done exactly at T+9 (N=4); second sweep issues V=EL+1 for every neuron.
- Backpressure: dp_ready held low 5 cycles on neuron 2 → dp_valid stays high, operands and cur_addr=2 stable, then sweep completes; done 5 cycles later than the zero-wait case.
- Spikes: model asserts dp_spike for neurons 1 and 3 → exactly two spike_valid pulses, with spike_id=1 then spike_id=3, each one cycle after its capture.
- Overrun: tick while busy and tick during the DONE cycle → no restart, overrun=1 and stays 1 across the next sweep; cleared only by rst.
- Mid-sweep reset: rst during WAIT of neuron 2, then dp_res_valid one cycle later → result ignored, all state back to reset values, busy=0, no spike_valid.
